mul_reservation_station: RTL and testbench

- Issue-side counterpart of the pipelined multiply unit, in the same out-of-order core.
- Accepts dispatched multiply instructions whose operands may still be pending.
- Captures pending operands and XER by snooping the common result bus (CDB).
- Issues the oldest fully-ready entry to the multiply unit over a registered valid/ready interface, tagging each issue with its own rs_id.

---
 rtl/ppc_types.sv | 29 ++
 rtl/mul_reservation_station_if.sv | 40 ++++
 rtl/rs_oldest_select.sv | 26 ++
 rtl/mul_reservation_station.sv | 117 +++++++++++
 tb/tb_mul_reservation_station.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ppc_types.sv
// ppc_types: shared decode and reservation-station entry types
package ppc_types;
  localparam int RS_TAG_MAX = 8;
  localparam int RS_AGE_W = 3;
  typedef struct packed {
    logic is_signed;
    logic mul_high;
    logic word_mode;
    logic oe;
    logic rc;
  } mul_decode_t;
  typedef struct packed {
    logic [31:0]           value;
    logic                  valid;
    logic [RS_TAG_MAX-1:0] tag;
  } rs_op_t;
  typedef struct packed {
    logic                busy;
    mul_decode_t         control;
    logic [4:0]          reg_addr;
    rs_op_t              op1;
    rs_op_t              op2;
    rs_op_t              xer;
    logic [RS_AGE_W-1:0] age;
  } rs_entry_t;
  function automatic rs_op_t rs_snoop(rs_op_t op, logic bc, logic [RS_TAG_MAX-1:0] tag, logic [31:0] v);
    return (!op.valid && bc && op.tag == tag) ? rs_op_t'{value: v, valid: 1'b1, tag: op.tag} : op;
  endfunction
endpackage

// File: rtl/mul_reservation_station_if.sv
// mul_reservation_station_if: dispatch, CDB and issue buses of the multiply station
interface mul_reservation_station_if #(parameter int RS_ID_WIDTH = 5);
  import ppc_types::*;
  logic                   dispatch_valid;
  logic                   dispatch_ready;
  mul_decode_t            dispatch_control;
  logic [4:0]             dispatch_result_reg_addr;
  logic [31:0]            dispatch_op1_value, dispatch_op2_value, dispatch_xer_value;
  logic                   dispatch_op1_valid, dispatch_op2_valid, dispatch_xer_valid;
  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag, dispatch_op2_tag, dispatch_xer_tag;
  logic                   cdb_valid;
  logic [RS_ID_WIDTH-1:0] cdb_rs_id;
  logic [31:0]            cdb_result;
  logic                   cdb_xer_valid;
  logic [31:0]            cdb_xer;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [RS_ID_WIDTH-1:0] issue_rs_id;
  logic [4:0]             issue_result_reg_addr;
  logic [31:0]            issue_op1, issue_op2, issue_xer;
  mul_decode_t            issue_control;
  modport slave (
    input  dispatch_valid, dispatch_control, dispatch_result_reg_addr,
           dispatch_op1_value, dispatch_op2_value, dispatch_xer_value,
           dispatch_op1_valid, dispatch_op2_valid, dispatch_xer_valid,
           dispatch_op1_tag, dispatch_op2_tag, dispatch_xer_tag,
           cdb_valid, cdb_rs_id, cdb_result, cdb_xer_valid, cdb_xer, issue_ready,
    output dispatch_ready, issue_valid, issue_rs_id, issue_result_reg_addr,
           issue_op1, issue_op2, issue_xer, issue_control
  );
  modport master (
    output dispatch_valid, dispatch_control, dispatch_result_reg_addr,
           dispatch_op1_value, dispatch_op2_value, dispatch_xer_value,
           dispatch_op1_valid, dispatch_op2_valid, dispatch_xer_valid,
           dispatch_op1_tag, dispatch_op2_tag, dispatch_xer_tag,
           cdb_valid, cdb_rs_id, cdb_result, cdb_xer_valid, cdb_xer, issue_ready,
    input  dispatch_ready, issue_valid, issue_rs_id, issue_result_reg_addr,
           issue_op1, issue_op2, issue_xer, issue_control
  );
endinterface

// File: rtl/rs_oldest_select.sv
// rs_oldest_select: one-hot grant of the ready entry with the smallest age rank
module rs_oldest_select #(
  parameter int N  = 4,
  parameter int AW = 3
) (
  input  logic [N-1:0]         ready,
  input  logic [N-1:0][AW-1:0] age,
  output logic [N-1:0]         grant,
  output logic                 found
);
  logic [AW-1:0] best;
  // scan all entries keeping the smallest-rank ready one; busy ranks are unique
  always_comb begin
    grant = '0;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (ready[i] && (!found || age[i] < best)) begin
        grant    = '0;
        grant[i] = 1'b1;
        best     = age[i];
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_reservation_station.sv
// mul_reservation_station: holds dispatched multiplies until operands arrive, issues oldest ready
module mul_reservation_station
  import ppc_types::*;
#(
  parameter int RS_ENTRIES  = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_BASE_ID  = 0
) (
  input logic clk,
  input logic rst,
  mul_reservation_station_if.slave bus
);
  rs_entry_t                              ent_q [RS_ENTRIES];
  rs_entry_t                              ent_d [RS_ENTRIES];
  rs_entry_t                              sel, new_ent;
  logic [RS_ENTRIES-1:0]                  busy, rdy, grant, free_oh;
  logic [RS_ENTRIES-1:0][RS_AGE_W-1:0]    ages;
  logic [RS_AGE_W:0]                      cnt;
  logic [RS_ID_WIDTH-1:0]                 sel_id;
  logic [RS_TAG_MAX-1:0]                  cdb_tag;
  logic                                   found, load, take, alloc, cdb_x;
  logic                                   iss_valid;

  assign cdb_tag            = RS_TAG_MAX'(bus.cdb_rs_id);
  assign cdb_x              = bus.cdb_valid & bus.cdb_xer_valid;
  assign free_oh            = ~busy & (busy + RS_ENTRIES'(1));
  assign bus.dispatch_ready = ~&busy;
  assign alloc              = bus.dispatch_valid & ~&busy;
  assign load               = ~iss_valid | bus.issue_ready;
  assign take               = load & found;
  assign cnt                = (RS_AGE_W+1)'($countones(busy));
  assign bus.issue_valid    = iss_valid;

  // per-entry status vectors from registered state only
  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      busy[i] = ent_q[i].busy;
      rdy[i]  = ent_q[i].busy & ent_q[i].op1.valid & ent_q[i].op2.valid & ent_q[i].xer.valid;
      ages[i] = ent_q[i].age;
    end
  end

  rs_oldest_select #(.N(RS_ENTRIES), .AW(RS_AGE_W)) u_sel (
    .ready(rdy), .age(ages), .grant(grant), .found(found)
  );

  // mux out the granted entry and its tag
  always_comb begin
    sel    = '0;
    sel_id = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (grant[i]) begin
        sel    = ent_q[i];
        sel_id = RS_ID_WIDTH'(RS_BASE_ID + i);
      end
    end
  end

  // incoming entry with same-cycle CDB bypass; rank counts the entry leaving this cycle
  always_comb begin
    new_ent          = '0;
    new_ent.busy     = 1'b1;
    new_ent.control  = bus.dispatch_control;
    new_ent.reg_addr = bus.dispatch_result_reg_addr;
    new_ent.op1      = rs_snoop(rs_op_t'{value: bus.dispatch_op1_value, valid: bus.dispatch_op1_valid,
                                tag: RS_TAG_MAX'(bus.dispatch_op1_tag)}, bus.cdb_valid, cdb_tag, bus.cdb_result);
    new_ent.op2      = rs_snoop(rs_op_t'{value: bus.dispatch_op2_value, valid: bus.dispatch_op2_valid,
                                tag: RS_TAG_MAX'(bus.dispatch_op2_tag)}, bus.cdb_valid, cdb_tag, bus.cdb_result);
    new_ent.xer      = rs_snoop(rs_op_t'{value: bus.dispatch_xer_value, valid: bus.dispatch_xer_valid,
                                tag: RS_TAG_MAX'(bus.dispatch_xer_tag)}, cdb_x, cdb_tag, bus.cdb_xer);
    new_ent.age      = RS_AGE_W'(cnt - (RS_AGE_W+1)'(take));
  end

  // next entry state: CDB capture, rank compaction, free on issue, then allocation
  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        ent_d[i].op1 = rs_snoop(ent_q[i].op1, bus.cdb_valid, cdb_tag, bus.cdb_result);
        ent_d[i].op2 = rs_snoop(ent_q[i].op2, bus.cdb_valid, cdb_tag, bus.cdb_result);
        ent_d[i].xer = rs_snoop(ent_q[i].xer, cdb_x, cdb_tag, bus.cdb_xer);
        ent_d[i].age = (take && ent_q[i].age > sel.age) ? ent_q[i].age - 1'b1 : ent_q[i].age;
      end
      if (take && grant[i]) ent_d[i].busy = 1'b0;
      if (alloc && free_oh[i]) ent_d[i] = new_ent;
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int i = 0; i < RS_ENTRIES; i++) ent_q[i] <= '0;
    else ent_q <= ent_d;
  end

  // issue register: refills whenever empty or being consumed, holds otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid                 <= 1'b0;
      bus.issue_rs_id           <= '0;
      bus.issue_result_reg_addr <= '0;
      bus.issue_op1             <= '0;
      bus.issue_op2             <= '0;
      bus.issue_xer             <= '0;
      bus.issue_control         <= '0;
    end else if (load) begin
      iss_valid <= found;
      if (found) begin
        bus.issue_rs_id           <= sel_id;
        bus.issue_result_reg_addr <= sel.reg_addr;
        bus.issue_op1             <= sel.op1.value;
        bus.issue_op2             <= sel.op2.value;
        bus.issue_xer             <= sel.xer.value;
        bus.issue_control         <= sel.control;
      end
    end
  end
endmodule

// File: tb/tb_mul_reservation_station.sv
// tb_mul_reservation_station: directed stimulus with a queue-based issue scoreboard
module tb_mul_reservation_station;
  import ppc_types::*;
  typedef struct {
    logic [4:0]  id;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] xer;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_reservation_station_if #(.RS_ID_WIDTH(5)) bus ();
  mul_reservation_station #(.RS_ENTRIES(4), .RS_ID_WIDTH(5), .RS_BASE_ID(0)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [4:0] id, rd, input logic [31:0] o1, o2, x);
    q.push_back('{id, rd, o1, o2, x});
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] v1, v2, vx,
                      input logic ok1, ok2, okx, input logic [4:0] t1, t2, tx);
    bus.dispatch_result_reg_addr = rd;
    bus.dispatch_control         = mul_decode_t'(rd);
    bus.dispatch_op1_value = v1; bus.dispatch_op1_valid = ok1; bus.dispatch_op1_tag = t1;
    bus.dispatch_op2_value = v2; bus.dispatch_op2_valid = ok2; bus.dispatch_op2_tag = t2;
    bus.dispatch_xer_value = vx; bus.dispatch_xer_valid = okx; bus.dispatch_xer_tag = tx;
    bus.dispatch_valid = 1'b1;
    tick();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    check("drain_pending", q.size(), 0);
    tick();
    tick();
  endtask

  // scoreboard monitor: every accepted issue must match the oldest expectation
  always @(negedge clk) begin
    if (rst && bus.issue_valid && bus.issue_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual rs_id=%0d op1=%0h required=no issue", bus.issue_rs_id, bus.issue_op1);
      end else begin
        e = q.pop_front();
        check("issue_rs_id", 32'(bus.issue_rs_id), 32'(e.id));
        check("issue_rd", 32'(bus.issue_result_reg_addr), 32'(e.rd));
        check("issue_op1", bus.issue_op1, e.op1);
        check("issue_op2", bus.issue_op2, e.op2);
        check("issue_xer", bus.issue_xer, e.xer);
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.dispatch_valid = 0; bus.dispatch_control = '0; bus.dispatch_result_reg_addr = 0;
    bus.dispatch_op1_value = 0; bus.dispatch_op2_value = 0; bus.dispatch_xer_value = 0;
    bus.dispatch_op1_valid = 0; bus.dispatch_op2_valid = 0; bus.dispatch_xer_valid = 0;
    bus.dispatch_op1_tag = 0; bus.dispatch_op2_tag = 0; bus.dispatch_xer_tag = 0;
    bus.cdb_valid = 0; bus.cdb_rs_id = 0; bus.cdb_result = 0; bus.cdb_xer_valid = 0; bus.cdb_xer = 0;
    bus.issue_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_issue_valid", 32'(bus.issue_valid), 0);
    check("rst_dispatch_ready", 32'(bus.dispatch_ready), 1);
    check("rst_issue_op1", bus.issue_op1, 0);
    check("rst_issue_rs_id", 32'(bus.issue_rs_id), 0);
    rst = 1'b1;
    tick();
    // all operands present: two-cycle latency
    bus.issue_ready = 1'b1;
    expect_issue(0, 3, 32'h3, 32'h5, 32'h0);
    disp(3, 32'h3, 32'h5, 32'h0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(bus.issue_valid), 0);
    tick();
    @(negedge clk);
    check("lat_cycle2_valid", 32'(bus.issue_valid), 1);
    tick();
    drain();
    // op2 pending on tag 7; unrelated tag 6 must be ignored
    expect_issue(0, 4, 32'h1, 32'h10, 32'h0);
    disp(4, 32'h1, 32'h0, 32'h0, 1, 0, 1, 0, 7, 0);
    bus.cdb_valid = 1; bus.cdb_rs_id = 6; bus.cdb_result = 32'h99;
    repeat (3) begin
      @(negedge clk);
      check("pend_no_issue", 32'(bus.issue_valid), 0);
      tick();
    end
    bus.cdb_rs_id = 7; bus.cdb_result = 32'h10;
    tick();
    bus.cdb_valid = 0;
    @(negedge clk);
    check("cdb_next_no_issue", 32'(bus.issue_valid), 0);
    tick();
    @(negedge clk);
    check("cdb_issue_valid", 32'(bus.issue_valid), 1);
    tick();
    drain();
    // same-cycle bypass of op1 and xer on tag 9
    bus.cdb_valid = 1; bus.cdb_rs_id = 9; bus.cdb_result = 32'hAB;
    bus.cdb_xer_valid = 1; bus.cdb_xer = 32'h2000_0000;
    expect_issue(0, 5, 32'hAB, 32'h2, 32'h2000_0000);
    disp(5, 32'h0, 32'h2, 32'h0, 0, 1, 0, 9, 0, 9);
    bus.cdb_valid = 0; bus.cdb_xer_valid = 0;
    drain();
    // age: A waits on tag 12, younger ready B overtakes
    expect_issue(1, 7, 32'h22, 32'h33, 32'h0);
    expect_issue(0, 6, 32'h44, 32'h1, 32'h0);
    disp(6, 32'h0, 32'h1, 32'h0, 0, 1, 1, 12, 0, 0);
    disp(7, 32'h22, 32'h33, 32'h0, 1, 1, 1, 0, 0, 0);
    tick();
    tick();
    bus.cdb_valid = 1; bus.cdb_rs_id = 12; bus.cdb_result = 32'h44;
    tick();
    bus.cdb_valid = 0;
    drain();
    // full with backpressure; older entry in higher index drains first
    bus.issue_ready = 1'b0;
    expect_issue(0, 8, 32'h100, 32'h1, 32'h0);
    expect_issue(1, 9, 32'h101, 32'h2, 32'h0);
    expect_issue(0, 10, 32'h102, 32'h3, 32'h0);
    expect_issue(2, 11, 32'h103, 32'h4, 32'h0);
    expect_issue(3, 12, 32'h104, 32'h5, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check("full_ready_before", 32'(bus.dispatch_ready), 1);
      disp(5'(8 + k), 32'h100 + 32'(k), 32'(k + 1), 32'h0, 1, 1, 1, 0, 0, 0);
    end
    check("full_ready_low", 32'(bus.dispatch_ready), 0);
    disp(13, 32'hDEAD, 32'hDEAD, 32'h0, 1, 1, 1, 0, 0, 0);
    check("full_still_low", 32'(bus.dispatch_ready), 0);
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.issue_valid), 1);
      check("hold_op1", bus.issue_op1, 32'h100);
      check("hold_rs_id", 32'(bus.issue_rs_id), 0);
      tick();
    end
    bus.issue_ready = 1'b1;
    drain();
    // reset with three busy entries and a held issue
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) disp(5'(20 + k), 32'h500 + 32'(k), 32'h7, 32'h0, 1, 1, 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_issue_valid", 32'(bus.issue_valid), 0);
    check("rst_mid_dispatch_ready", 32'(bus.dispatch_ready), 1);
    check("rst_mid_issue_op1", bus.issue_op1, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.issue_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", 32'(bus.issue_valid), 0);
    end
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
